// File: rtl/alu_cla_pkg.sv
// rtl/alu_cla_pkg.sv - shared constants, state encoding and P/G polarity helpers
//
// Contents:
//   CHUNK            bits handled per sequencer cycle by the lookahead group
//   seq_state_t      sequencer FSM states
//   pg_low_to_high   convert one active-low P/G term to active-high
//   pg4_high_to_low  convert four active-high P/G terms to active-low
//   pg4_low_to_high  convert four active-low P/G terms to active-high
package alu_cla_pkg;

  localparam int CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic logic pg_low_to_high(input logic lo);
    return ~lo;
  endfunction

  function automatic logic [3:0] pg4_high_to_low(input logic [3:0] hi);
    return ~hi;
  endfunction

  function automatic logic [3:0] pg4_low_to_high(input logic [3:0] lo);
    return ~lo;
  endfunction

endpackage

// File: rtl/cla_group16.sv
// rtl/cla_group16.sv - combinational 16-bit adder built from four 4-bit slices and one 74182 unit
//
// Ports:
//   a, b  in   16-bit addends
//   cin   in   carry-in
//   sum   out  16-bit sum
//   cout  out  carry-out of bit 15
//   gb    out  group generate, active-low (carry-out assuming cin=0)
//   pb    out  group propagate, active-low (AND of a^b over all bits)
module cla_group16
  import alu_cla_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        gb,
  output logic        pb
);

  logic [15:0] bit_p;
  logic [15:0] bit_g;
  logic [3:0]  slice_p;
  logic [3:0]  slice_g;
  logic [3:0]  slice_c;
  logic [15:0] bit_c;
  logic        cnx;
  logic        cny;
  logic        cnz;

  // Propagate is XOR so the same term also forms the sum bit.
  assign bit_p = a ^ b;
  assign bit_g = a & b;

  for (genvar s = 0; s < 4; s++) begin : g_slice
    assign slice_p[s] = &bit_p[4*s +: 4];
    assign slice_g[s] = bit_g[4*s+3]
                      | (bit_p[4*s+3] & bit_g[4*s+2])
                      | (bit_p[4*s+3] & bit_p[4*s+2] & bit_g[4*s+1])
                      | (bit_p[4*s+3] & bit_p[4*s+2] & bit_p[4*s+1] & bit_g[4*s]);
  end

  cla_ic_74182b u_cla (
    .cn  (cin),
    .pb  (pg4_high_to_low(slice_p)),
    .gb  (pg4_high_to_low(slice_g)),
    .cnx (cnx),
    .cny (cny),
    .cnz (cnz),
    .pbo (pb),
    .gbo (gb)
  );

  assign slice_c = {cnz, cny, cnx, cin};

  // Inside a slice the carry ripples across only three bit positions.
  always_comb begin
    bit_c = '0;
    for (int s = 0; s < 4; s++) begin
      bit_c[4*s] = slice_c[s];
      for (int j = 0; j < 3; j++) begin
        bit_c[4*s+j+1] = bit_g[4*s+j] | (bit_p[4*s+j] & bit_c[4*s+j]);
      end
    end
  end

  assign sum  = bit_p ^ bit_c;
  assign cout = pg_low_to_high(gb) | (pg_low_to_high(pb) & cin);

endmodule

// File: rtl/cla_ic_74182b.sv
// rtl/cla_ic_74182b.sv - 74182-style 4-group carry-lookahead unit
//
// Ports:
//   cn    in   carry into group 0 (active-high)
//   pb    in   group propagate terms, active-low
//   gb    in   group generate terms, active-low
//   cnx   out  carry into group 1 (active-high)
//   cny   out  carry into group 2 (active-high)
//   cnz   out  carry into group 3 (active-high)
//   pbo   out  block propagate, active-low
//   gbo   out  block generate, active-low
module cla_ic_74182b
  import alu_cla_pkg::*;
(
  input  logic       cn,
  input  logic [3:0] pb,
  input  logic [3:0] gb,
  output logic       cnx,
  output logic       cny,
  output logic       cnz,
  output logic       pbo,
  output logic       gbo
);

  logic [3:0] p;
  logic [3:0] g;

  assign p = pg4_low_to_high(pb);
  assign g = pg4_low_to_high(gb);

  assign cnx = g[0] | (p[0] & cn);
  assign cny = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cn);
  assign cnz = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cn);

  // Block outputs exclude cn, so gbo is the carry-out for a zero carry-in.
  assign gbo = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
  assign pbo = ~(&p);

endmodule

// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - multi-cycle WIDTH-bit add/subtract using one shared 16-bit lookahead group
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid, in_ready   operation handshake
//   a, b, cin, sub       operands, carry-in (add only), subtract select
//   out_valid, out_ready result handshake
//   sum, cout, ovf, zero result and flags, held stable while out_valid
//   word_p, word_g       whole-word propagate / generate (active-high)
//   busy                 high whenever the sequencer is not idle
module cla_word_sequencer
  import alu_cla_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             word_p,
  output logic             word_g,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_width
    $error("cla_word_sequencer: WIDTH must be a positive multiple of 16");
  end

  seq_state_t       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_gb;
  logic             chunk_pb;
  logic             chunk_g;
  logic             chunk_p;
  logic [WIDTH-1:0] sum_next;

  assign chunk_a = a_r[CHUNK*idx +: CHUNK];
  assign chunk_b = b_r[CHUNK*idx +: CHUNK];

  cla_group16 u_group (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .gb   (chunk_gb),
    .pb   (chunk_pb)
  );

  assign chunk_g = pg_low_to_high(chunk_gb);
  assign chunk_p = pg_low_to_high(chunk_pb);

  // Result as it will look after this cycle's chunk lands; the flags taken
  // on the last RUN cycle are derived from it so they appear with out_valid.
  always_comb begin
    sum_next = sum;
    sum_next[CHUNK*idx +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      word_p    <= 1'b0;
      word_g    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            word_p   <= 1'b1;
            word_g   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          sum    <= sum_next;
          carry  <= chunk_cout;
          word_g <= chunk_g | (chunk_p & word_g);
          word_p <= word_p & chunk_p;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            cout      <= chunk_cout;
            zero      <= (sum_next == '0);
            ovf       <= (a_r[MSB] == b_r[MSB]) && (sum_next[MSB] != a_r[MSB]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb/tb_cla_word_sequencer.sv - directed self-checking bench for cla_word_sequencer
module tb_cla_word_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         word_p;
  logic         word_g;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cla_word_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .word_p    (word_p),
    .word_g    (word_g),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk1("accept_ready", in_ready, 1'b1);
    a = ta;
    b = tb;
    cin = tcin;
    sub = tsub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen_valid;

    // Reset held for two edges
    rst_n = 1'b0;
    tick();
    chk1("rst_in_ready_0", in_ready, 1'b0);
    tick();
    chk1("rst_in_ready_1", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 64'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_word_p", word_p, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rel_in_ready", in_ready, 1'b1);

    // Full-width carry ripple
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk1("run_busy", busy, 1'b1);
    chk1("run_in_ready", in_ready, 1'b0);
    wait_done("ripple");
    chk("ripple_sum", sum, 64'd0);
    chk1("ripple_cout", cout, 1'b1);
    chk1("ripple_ovf", ovf, 1'b0);
    chk1("ripple_zero", zero, 1'b1);
    chk1("ripple_word_p", word_p, 1'b0);
    chk1("ripple_word_g", word_g, 1'b1);
    consume();
    chk1("ripple_out_valid_clr", out_valid, 1'b0);

    // Subtract, cin must be ignored
    issue(64'd5, 64'd7, 1'b1, 1'b1);
    wait_done("sub");
    chk("sub_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk1("sub_cout", cout, 1'b0);
    chk1("sub_ovf", ovf, 1'b0);
    chk1("sub_zero", zero, 1'b0);
    chk1("sub_word_p", word_p, 1'b0);
    chk1("sub_word_g", word_g, 1'b0);
    consume();

    // Signed overflow
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done("ovf");
    chk("ovf_sum", sum, 64'h8000_0000_0000_0000);
    chk1("ovf_ovf", ovf, 1'b1);
    chk1("ovf_cout", cout, 1'b0);
    chk1("ovf_zero", zero, 1'b0);
    consume();

    // All-propagate word with cin=1: word_g excludes the carry-in
    issue(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_done("prop");
    chk("prop_sum", sum, 64'd0);
    chk1("prop_cout", cout, 1'b1);
    chk1("prop_zero", zero, 1'b1);
    chk1("prop_word_p", word_p, 1'b1);
    chk1("prop_word_g", word_g, 1'b0);
    consume();

    // Backpressure with a competing request
    issue(64'h1000, 64'h0234, 1'b0, 1'b0);
    wait_done("bp");
    a = 64'd1;
    b = 64'd1;
    cin = 1'b0;
    sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum", sum, 64'h1234);
      chk1("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    consume();
    chk1("bp_after_out_valid", out_valid, 1'b0);
    chk1("bp_after_busy", busy, 1'b0);
    chk1("bp_after_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1("bp_new_accepted", busy, 1'b1);
    wait_done("bp2");
    chk("bp2_sum", sum, 64'd2);
    consume();

    // Abort in RUN at idx=2
    issue(64'hABCD, 64'h1111, 1'b0, 1'b0);
    tick();
    tick();
    chk1("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    chk1("abort_no_valid", seen_valid, 1'b0);
    chk1("abort_idle_ready", in_ready, 1'b1);

    issue(64'd3, 64'd4, 1'b0, 1'b0);
    wait_done("post");
    chk("post_sum", sum, 64'd7);
    chk1("post_cout", cout, 1'b0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
